// File: rtl/serial_parity_gen_if.sv
// Serial parity generator bus interface.
// Groups the frame-request, serial-data and result signals of one
// serial_parity_gen instance.
//   start     : frame-start request (master -> slave)
//   din       : serial data bit (master -> slave)
//   din_valid : qualifies din (master -> slave)
//   parity    : parity of the last completed frame (slave -> master)
//   done      : one-cycle completion pulse (slave -> master)
//   busy      : high while bits are being accumulated (slave -> master)
//   bit_cnt   : bits accepted in the current/last frame (slave -> master)
// NBITS must match the NBITS of the attached serial_parity_gen.
interface serial_parity_gen_if #(
    parameter int NBITS = 8
);
    localparam int CW = $clog2(NBITS + 1);

    logic          start;
    logic          din;
    logic          din_valid;
    logic          parity;
    logic          done;
    logic          busy;
    logic [CW-1:0] bit_cnt;

    modport master (
        output start, din, din_valid,
        input  parity, done, busy, bit_cnt
    );

    modport slave (
        input  start, din, din_valid,
        output parity, done, busy, bit_cnt
    );
endinterface

// File: rtl/serial_parity_gen.sv
// Serial parity generator.
// Accumulates NBITS qualified serial bits after a start request and
// reports their even (ODD=0) or odd (ODD=1) parity with a one-cycle done
// pulse. parity and bit_cnt hold until the next frame changes them.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : serial_parity_gen_if slave modport (start, din, din_valid in;
//         parity, done, busy, bit_cnt out)
module serial_parity_gen #(
    parameter int NBITS = 8,
    parameter bit ODD   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    serial_parity_gen_if.slave  bus
);
    localparam int            CW    = $clog2(NBITS + 1);
    localparam logic [CW-1:0] LAST  = CW'(NBITS - 1);
    localparam logic [CW-1:0] FULL  = CW'(NBITS);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Running parity: fold one more bit into the accumulated value.
    function automatic logic parity_step(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

    state_t        state_r;
    state_t        state_s;
    logic          acc_r;
    logic          acc_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          parity_r;
    logic          parity_s;
    logic          done_r;
    logic          busy_r;

    // Next-state, accumulator, counter and result computation.
    always_comb begin
        state_s  = state_r;
        acc_s    = acc_r;
        cnt_s    = cnt_r;
        parity_s = parity_r;
        case (state_r)
            IDLE: begin
                // din/din_valid are deliberately ignored here, even
                // in the cycle start is sampled.
                if (bus.start) begin
                    state_s = ACCUM;
                    acc_s   = ODD;
                    cnt_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (bus.din_valid) begin
                    if (cnt_r == LAST) begin
                        // Last bit goes straight into the result so it is
                        // visible together with done.
                        parity_s = parity_step(acc_r, bus.din);
                        acc_s    = parity_step(acc_r, bus.din);
                        cnt_s    = FULL;
                        state_s  = DONE;
                    end else begin
                        acc_s = parity_step(acc_r, bus.din);
                        cnt_s = cnt_r + ONE;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; done/busy are decoded from the next
    // state so they are registered yet aligned with the state they mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            acc_r    <= 1'b0;
            cnt_r    <= '0;
            parity_r <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            acc_r    <= acc_s;
            cnt_r    <= cnt_s;
            parity_r <= parity_s;
            done_r   <= (state_s == DONE);
            busy_r   <= (state_s == ACCUM);
        end
    end

    assign bus.parity  = parity_r;
    assign bus.done    = done_r;
    assign bus.busy    = busy_r;
    assign bus.bit_cnt = cnt_r;
endmodule

// File: tb/tb_serial_parity_gen.sv
module tb_serial_parity_gen;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic last_par0;
    logic last_par1;

    serial_parity_gen_if #(.NBITS(8)) if0 ();
    serial_parity_gen_if #(.NBITS(8)) if1 ();
    serial_parity_gen_if #(.NBITS(1)) if2 ();

    serial_parity_gen #(.NBITS(8), .ODD(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    serial_parity_gen #(.NBITS(8), .ODD(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    serial_parity_gen #(.NBITS(1), .ODD(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic s, input logic d, input logic v);
        if0.start = s; if0.din = d; if0.din_valid = v;
        if1.start = s; if1.din = d; if1.din_valid = v;
        if2.start = s; if2.din = d; if2.din_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        last_par0 = 1'b0;
        last_par1 = 1'b0;
    endtask

    // One 8-bit frame on dut0/dut1. gap_on inserts 1..3 idle cycles
    // between bits; start_at pulses start before that bit index (-1 = none).
    task automatic run_frame(input string name, input logic [7:0] bits,
                             input bit gap_on, input int start_at,
                             input logic exp0, input logic exp1);
        drive(1'b1, 1'b1, 1'b1);   // din_valid in IDLE must be ignored
        tick();
        drive(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (if0.busy !== 1'b1 || if0.bit_cnt !== 4'd0 || if0.done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s start: busy=%b cnt=%0d done=%b, want busy=1 cnt=0 done=0",
                     name, if0.busy, if0.bit_cnt, if0.done);
        end
        for (int i = 0; i < 8; i++) begin
            if (gap_on && i > 0) begin
                for (int g = 0; g < ((i - 1) % 3) + 1; g++) begin
                    drive(1'b0, 1'b1, 1'b0);
                    tick();
                    n_cmp++;
                    if (if0.bit_cnt !== 4'(i) || if0.done !== 1'b0 || if0.busy !== 1'b1) begin
                        n_bad++;
                        $display("FAIL %s gap bit%0d: cnt=%0d done=%b busy=%b, want cnt=%0d done=0 busy=1",
                                 name, i, if0.bit_cnt, if0.done, if0.busy, i);
                    end
                end
            end
            if (i == start_at) begin
                drive(1'b1, 1'b0, 1'b0);
                tick();
                n_cmp++;
                if (if0.bit_cnt !== 4'(i) || if0.busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s start_in_accum: cnt=%0d busy=%b, want cnt=%0d busy=1",
                             name, if0.bit_cnt, if0.busy, i);
                end
            end
            drive(1'b0, bits[i], 1'b1);
            tick();
            drive(1'b0, 1'b0, 1'b0);
            if (i < 7) begin
                n_cmp++;
                if (if0.bit_cnt !== 4'(i + 1) || if0.busy !== 1'b1 || if0.done !== 1'b0 ||
                    if0.parity !== last_par0) begin
                    n_bad++;
                    $display("FAIL %s bit%0d: cnt=%0d busy=%b done=%b par=%b, want cnt=%0d busy=1 done=0 par=%b",
                             name, i, if0.bit_cnt, if0.busy, if0.done, if0.parity, i + 1, last_par0);
                end
            end else begin
                n_cmp++;
                if (if0.done !== 1'b1 || if0.busy !== 1'b0 || if0.bit_cnt !== 4'd8 ||
                    if0.parity !== exp0 || if1.parity !== exp1 || if1.done !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s done: done=%b busy=%b cnt=%0d par0=%b par1=%b, want 1 0 8 %b %b",
                             name, if0.done, if0.busy, if0.bit_cnt, if0.parity, if1.parity, exp0, exp1);
                end
            end
        end
        last_par0 = exp0;
        last_par1 = exp1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        tick();
        n_cmp++;
        if (if0.parity !== 1'b0 || if0.done !== 1'b0 || if0.busy !== 1'b0 || if0.bit_cnt !== 4'd0 ||
            if1.parity !== 1'b0 || if1.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: par=%b done=%b busy=%b cnt=%0d par1=%b busy1=%b, want all 0",
                     if0.parity, if0.done, if0.busy, if0.bit_cnt, if1.parity, if1.busy);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        run_frame("basic", 8'b0100_1101, 1'b0, -1, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (if0.done !== 1'b0 || if0.bit_cnt !== 4'd8 || if0.parity !== 1'b0 || if1.parity !== 1'b1) begin
            n_bad++;
            $display("FAIL basic hold: done=%b cnt=%0d par0=%b par1=%b, want 0 8 0 1",
                     if0.done, if0.bit_cnt, if0.parity, if1.parity);
        end
    endtask

    task automatic test_odd_even();
        do_reset();
        run_frame("odd_even", 8'b0000_0111, 1'b0, -1, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_gaps();
        run_frame("gaps", 8'b0100_1101, 1'b1, -1, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_start_in_accum();
        run_frame("start_accum", 8'b0000_0111, 1'b0, 3, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);   // bit offered in DONE is dropped
        tick();
        drive(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.bit_cnt !== 4'd8 || if0.parity !== 1'b1) begin
            n_bad++;
            $display("FAIL done_drop: busy=%b done=%b cnt=%0d par=%b, want 0 0 8 1",
                     if0.busy, if0.done, if0.bit_cnt, if0.parity);
        end
        tick();
        n_cmp++;
        if (if0.busy !== 1'b0 || if0.bit_cnt !== 4'd8) begin
            n_bad++;
            $display("FAIL no_restart: busy=%b cnt=%0d, want 0 8", if0.busy, if0.bit_cnt);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            tick();
        end
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (if0.busy !== 1'b0 || if0.bit_cnt !== 4'd0 || if0.parity !== 1'b0 || if0.done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: busy=%b cnt=%0d par=%b done=%b, want all 0",
                     if0.busy, if0.bit_cnt, if0.parity, if0.done);
        end
        last_par0 = 1'b0;
        last_par1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (if0.done !== 1'b0 || if0.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_mid idle%0d: done=%b busy=%b, want 0 0", i, if0.done, if0.busy);
            end
        end
        run_frame("after_reset", 8'hFF, 1'b0, -1, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_1", 8'b0000_0111, 1'b0, -1, 1'b1, 1'b0);
        tick();   // DONE -> IDLE; start follows in this IDLE cycle
        run_frame("b2b_2", 8'b0100_1101, 1'b0, -1, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_nbits1();
        do_reset();
        for (int f = 0; f < 2; f++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
            n_cmp++;
            if (if2.busy !== 1'b1 || if2.bit_cnt !== 1'b0) begin
                n_bad++;
                $display("FAIL nbits1 start%0d: busy=%b cnt=%0d, want 1 0", f, if2.busy, if2.bit_cnt);
            end
            drive(1'b0, (f == 0) ? 1'b1 : 1'b0, 1'b1);
            tick();
            drive(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (if2.done !== 1'b1 || if2.busy !== 1'b0 || if2.bit_cnt !== 1'b1 ||
                if2.parity !== ((f == 0) ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL nbits1 frame%0d: done=%b busy=%b cnt=%0d par=%b, want 1 0 1 %b",
                         f, if2.done, if2.busy, if2.bit_cnt, if2.parity, (f == 0) ? 1'b1 : 1'b0);
            end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_odd_even();
        test_gaps();
        test_start_in_accum();
        test_reset_mid();
        test_back_to_back();
        test_nbits1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_parity_gen.md
SERIAL_PARITY_GEN -- requirements
Module: serial_parity_gen

Interface
REQ-001 The block SHALL have parameter NBITS, default 8, giving the number of data bits per frame (legal range 1..64).
REQ-002 The block SHALL have parameter ODD, default 0, selecting parity sense: 0 = even parity, 1 = odd parity.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port start  input  1  frame-start request, sampled only in IDLE.
REQ-006 The block SHALL have port din  input  1  serial data bit, LSB-first order irrelevant to result.
REQ-007 The block SHALL have port din_valid  input  1  qualifies din; a bit is accepted only when high in ACCUM.
REQ-008 The block SHALL have port parity  output  1  registered parity result of the last completed frame.
REQ-009 The block SHALL have port done  output  1  registered one-cycle pulse marking parity valid for a new frame.
REQ-010 The block SHALL have port busy  output  1  high while in ACCUM.
REQ-011 The block SHALL have port bit_cnt  output  $clog2(NBITS+1)  count of bits accepted in the current/last frame.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-013 In IDLE with start=1, the block SHALL go to ACCUM on the next edge, load the internal accumulator with ODD, and clear bit_cnt to 0.
REQ-014 In IDLE, din_valid and din SHALL be ignored, including in the cycle start is sampled.
REQ-015 In ACCUM, each edge with din_valid=1 SHALL update accumulator <= accumulator XOR din and increment bit_cnt by 1.
REQ-016 In ACCUM, edges with din_valid=0 SHALL leave the accumulator and bit_cnt unchanged (no timeout).
REQ-017 When the NBITS-th bit is accepted, the same edge SHALL load parity <= accumulator XOR din, set bit_cnt = NBITS, and move to DONE.
REQ-018 done SHALL be high for exactly the one cycle spent in DONE; DONE SHALL unconditionally return to IDLE on the next edge.
REQ-019 Latency: parity and done SHALL be visible in the cycle immediately following the edge that samples the last bit.
REQ-020 start SHALL be ignored in ACCUM and DONE; no frame restart or abort occurs via start.
REQ-021 din_valid in DONE SHALL be ignored; bits presented there are dropped.
REQ-022 parity and bit_cnt SHALL hold their values through DONE and IDLE until changed by REQ-013/REQ-017 (parity changes only at frame completion).
REQ-023 With NBITS=1, a single accepted bit SHALL complete the frame: parity = ODD XOR din.
REQ-024 busy SHALL be 1 exactly when state is ACCUM; done and busy SHALL never be high together.

Reset
REQ-025 When rst=1 at a rising edge, the block SHALL enter IDLE and set parity=0, done=0, busy=0, bit_cnt=0, accumulator=0, overriding all other inputs.
REQ-026 rst asserted mid-frame SHALL abandon the frame with no done pulse; the next start SHALL begin a clean frame.
REQ-027 Reset SHALL take effect only at a clock edge; outputs SHALL not change asynchronously.

Verification
REQ-028 NBITS=8, ODD=0, start then 8 consecutive valid bits 1,0,1,1,0,0,1,0 -> parity=0, done high for one cycle after 8th bit edge, bit_cnt=8.
REQ-029 NBITS=8, bits 1,1,1,0,0,0,0,0 -> parity=1 with ODD=0; same bits with ODD=1 -> parity=0.
REQ-030 Same 8 bits as REQ-028 with din_valid low for 1-3 cycles between bits -> parity=0, bit_cnt stalls during gaps, done only after 8th valid bit.
REQ-031 start pulsed during ACCUM after 3 bits, plus din_valid in DONE -> frame completes after 8 total bits with correct parity, no restart, extra bit dropped.
REQ-032 rst after 5 accepted bits -> next cycle busy=0, bit_cnt=0, parity=0, done=0, no done pulse; new frame of 8 ones -> parity=0.
REQ-033 Back-to-back frames: start asserted in the IDLE cycle right after done -> second frame accepted, parity from frame 1 held until frame 2 completes.
